// File: rtl/cpu_types_pkg.sv
// Shared datapath types: machine word plus instruction cache frame, address and state definitions.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, single-word blocking fills.
module icache
  import cpu_types_pkg::*;
#(
  parameter  int NUM_SETS = ICACHE_SETS,
  localparam int IDX_W    = $clog2(NUM_SETS)
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  word_t iload,
  input  logic  iwait,
  input  logic  icflush,
  output word_t hit_count,
  output word_t miss_count
);

  localparam int TAG_W = 30 - IDX_W;

  logic [NUM_SETS-1:0] valid;
  logic [TAG_W-1:0]    tags [NUM_SETS];
  word_t               data [NUM_SETS];

  icache_state_t       state, state_nxt;
  logic [29:0]         miss_word;
  logic [IDX_W-1:0]    req_idx, fill_idx;
  logic [TAG_W-1:0]    req_tag, fill_tag;
  logic                hit, miss_start, fill_done;
  logic                unused_bytoff;

  assign req_idx       = imemaddr[IDX_W+1:2];
  assign req_tag       = imemaddr[31:IDX_W+2];
  assign fill_idx      = miss_word[IDX_W-1:0];
  assign fill_tag      = miss_word[29:IDX_W];
  assign unused_bytoff = ^imemaddr[1:0];

  assign hit = imemREN & valid[req_idx] & (tags[req_idx] == req_tag);

  always_comb begin
    state_nxt  = state;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    miss_start = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        ihit = hit;
        if (hit) imemload = data[req_idx];
        if (imemREN && !hit) begin
          miss_start = 1'b1;
          state_nxt  = FILL;
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = {miss_word, 2'b00};
        // A flush drops the outstanding fill even if its data arrives now.
        if (icflush) begin
          state_nxt = IDLE;
        end else if (!iwait) begin
          fill_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      valid      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_nxt;
      if (icflush)        valid           <= '0;
      else if (fill_done) valid[fill_idx] <= 1'b1;
      if (ihit)       hit_count  <= hit_count + 32'd1;
      if (miss_start) miss_count <= miss_count + 32'd1;
    end
  end

  // Tags, data and the miss address are only meaningful behind valid/state.
  always_ff @(posedge CLK) begin
    if (miss_start) miss_word <= imemaddr[31:2];
    if (fill_done) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus queues expected hits and fills, monitors pop and compare.
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        icflush;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .ihit      (ihit),
    .imemload  (imemload),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iload     (iload),
    .iwait     (iwait),
    .icflush   (icflush),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int          n_cmp = 0;
  int          n_err = 0;
  int          mem_wait = 0;
  int          exp_hits = 0;
  int          exp_miss = 0;
  logic [31:0] hitq[$];
  logic [31:0] fillq[$];
  int          lenq[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h3C010001 ^ {a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Memory controller model: holds iwait high mem_wait cycles of each fill.
  initial begin
    int cnt;
    cnt   = 0;
    iwait = 1'b1;
    iload = '0;
    forever begin
      @(posedge CLK); #1;
      if (iREN) begin
        if (cnt < mem_wait) begin
          iwait = 1'b1;
          cnt++;
        end else begin
          iwait = 1'b0;
          iload = mem(iaddr);
          cnt   = 0;
        end
      end else begin
        iwait = 1'b1;
        cnt   = 0;
      end
    end
  end

  // Hit monitor
  always @(negedge CLK) begin
    if (ihit === 1'b1) begin
      if (hitq.size() == 0) check("unexpected_hit", imemaddr, 32'hFFFFFFFF);
      else check("hit_data", imemload, hitq.pop_front());
    end
  end

  // Fill monitor: address per fill, address stability, and iREN length
  bit          in_fill = 0;
  int          flen = 0, fexp = 0;
  logic [31:0] faddr = '0;
  always @(negedge CLK) begin
    if (iREN === 1'b1) begin
      if (!in_fill) begin
        in_fill = 1;
        flen    = 1;
        if (fillq.size() == 0) begin
          check("unexpected_fill", iaddr, 32'hFFFFFFFF);
          faddr = iaddr;
          fexp  = 0;
        end else begin
          faddr = fillq.pop_front();
          fexp  = lenq.pop_front();
          check("fill_addr", iaddr, faddr);
        end
      end else begin
        flen++;
        check("fill_addr_stable", iaddr, faddr);
      end
    end else if (in_fill) begin
      in_fill = 0;
      check("fill_len", flen, fexp);
    end
  end

  task automatic wait_hit();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (ihit === 1'b1) seen = 1;
    end
    if (!seen) check("hit_timeout", imemaddr, 32'hFFFFFFFF);
  endtask

  task automatic fetch(input logic [31:0] a, input bit miss, input int w);
    @(posedge CLK); #1;
    mem_wait = w;
    imemREN  = 1'b1;
    imemaddr = a;
    if (miss) begin
      exp_miss++;
      fillq.push_back(a);
      lenq.push_back(w + 1);
    end
    hitq.push_back(mem(a));
    exp_hits++;
    wait_hit();
  endtask

  task automatic idle();
    @(posedge CLK); #1;
    imemREN = 1'b0;
  endtask

  task automatic check_counts(input string tag);
    idle();
    @(negedge CLK);
    check({tag, "_hit_count"}, hit_count, exp_hits);
    check({tag, "_miss_count"}, miss_count, exp_miss);
  endtask

  initial begin
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = '0;
    icflush  = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("reset_ihit", ihit, 0);
    check("reset_iREN", iREN, 0);
    check("reset_hit_count", hit_count, 0);
    check("reset_miss_count", miss_count, 0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // Cold miss, memory busy two cycles
    fetch(32'h0, 1, 2);
    check_counts("cold");

    // Fill 0x4, 0x8, 0xC, then a back-to-back hit pass
    fetch(32'h4, 1, 1);
    fetch(32'h8, 1, 0);
    fetch(32'hC, 1, 3);
    check_counts("seqfill");
    for (int i = 0; i < 4; i++) fetch(32'(i * 4), 0, 0);
    check_counts("seqhit");

    // Conflict on index 1
    fetch(32'h44, 1, 0);
    fetch(32'h4, 1, 0);
    check_counts("conflict");

    // Address change while the fill for 0x10 is pending
    @(posedge CLK); #1;
    mem_wait = 2;
    imemREN  = 1'b1;
    imemaddr = 32'h10;
    exp_miss++;
    fillq.push_back(32'h10);
    lenq.push_back(3);
    @(posedge CLK); #1;
    imemaddr = 32'h20;
    exp_miss++;
    fillq.push_back(32'h20);
    lenq.push_back(3);
    hitq.push_back(mem(32'h20));
    exp_hits++;
    wait_hit();
    fetch(32'h10, 0, 0);
    check_counts("midfill");

    // Flush during the fill for 0x8
    fetch(32'h48, 1, 0);
    @(posedge CLK); #1;
    mem_wait = 3;
    imemaddr = 32'h8;
    exp_miss++;
    fillq.push_back(32'h8);
    lenq.push_back(1);
    @(posedge CLK); #1;
    icflush = 1'b1;
    @(posedge CLK); #1;
    icflush = 1'b0;
    imemREN = 1'b0;
    @(negedge CLK);
    check("flush_iREN", iREN, 0);
    fetch(32'h8, 1, 1);
    fetch(32'h0, 1, 0);
    fetch(32'h4, 1, 0);
    fetch(32'hC, 1, 0);
    fetch(32'h10, 1, 1);
    fetch(32'h20, 1, 0);
    fetch(32'h48, 1, 0);
    check_counts("flush");

    // Reset while filling 0x14
    @(posedge CLK); #1;
    mem_wait = 3;
    imemREN  = 1'b1;
    imemaddr = 32'h14;
    fillq.push_back(32'h14);
    lenq.push_back(1);
    @(posedge CLK); #1;
    nRST    = 1'b0;
    imemREN = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    check("rst_fill_iREN", iREN, 0);
    check("rst_fill_hit_count", hit_count, 0);
    check("rst_fill_miss_count", miss_count, 0);
    exp_hits = 0;
    exp_miss = 0;
    fetch(32'h0, 1, 0);
    fetch(32'h4, 1, 0);
    check_counts("post_reset");

    // Hit counter wrap
    idle();
    force dut.hit_count = 32'hFFFFFFFF;
    #1;
    release dut.hit_count;
    fetch(32'h4, 0, 0);
    idle();
    @(negedge CLK);
    check("hit_count_wrap", hit_count, 32'h0);

    repeat (2) @(negedge CLK);
    check("hitq_drained", hitq.size(), 0);
    check("fillq_drained", fillq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
Direct-mapped, read-only instruction cache serving the fetch side of the datapath. It answers the program counter's fetch requests (imemREN/imemaddr) with ihit/imemload. It fills misses from the memory controller through the iREN/iaddr/iload/iwait interface. Hits are zero-latency. A miss stalls the front end until the line is installed.

Parameters:
NUM_SETS, 16, number of one-word frames; power of two, at least 2.
IDX_W, $clog2(NUM_SETS), index width, derived and not overridden.

Ports:
CLK  input  1  clock; all state changes on the rising edge
nRST  input  1  reset, synchronous, active-low
imemREN  input  1  fetch request from the datapath
imemaddr  input  32  fetch byte address
ihit  output  1  requested word valid this cycle; the PC advances on it
imemload  output  32  instruction word
iREN  output  1  fill request to the memory controller
iaddr  output  32  fill word address
iload  input  32  fill data from the memory controller
iwait  input  1  high while the memory controller is busy; fill data is valid in a cycle where iREN=1 and iwait=0
icflush  input  1  invalidate all frames
hit_count  output  32  number of cycles with ihit=1
miss_count  output  32  number of misses serviced

Behaviour:
- Reset is synchronous and active-low: when nRST=0 at a CLK edge, reset takes effect.
  - All valid bits clear.
  - State goes to IDLE.
  - hit_count and miss_count go to 0.
  - Tags and data need not reset.
- Address split:
  - byte offset = imemaddr[1:0], ignored.
  - index = imemaddr[IDX_W+1:2].
  - tag = imemaddr[31:IDX_W+2].
- Frame contents: valid bit, tag, 32-bit data.
- Hit definition: hit = imemREN & frame[index].valid & (frame[index].tag == tag).
- State IDLE:
  - ihit = hit, combinational.
  - imemload = frame[index].data whenever hit; otherwise imemload = 0.
  - iREN = 0; iaddr = 0.
  - If imemREN=1 and there is no hit: latch {imemaddr[31:2], 2'b00} into miss_addr, increment miss_count, and go to FILL.
- State FILL:
  - ihit = 0.
  - iREN = 1; iaddr = miss_addr.
  - When iwait=0: write valid=1, tag(miss_addr) and iload into frame[index(miss_addr)], then go to IDLE.
  - The next cycle re-evaluates the request and hits if the address is unchanged.
- Miss latency with memory wait W: the detect cycle, plus W+1 FILL cycles, plus 1 hit cycle. ihit rises W+2 cycles after the miss cycle.
- A fill is never aborted by the datapath. If imemaddr changes or imemREN drops during FILL, the fill still completes and installs miss_addr.
- icflush:
  - At the edge, clears all valid bits.
  - In IDLE, combinational ihit for the current cycle is unaffected.
  - In FILL, the fill is dropped: nothing is installed, iREN falls the next cycle, and the state goes to IDLE.
  - icflush takes priority over a completing fill in the same cycle.
- hit_count increments on every cycle with ihit=1.
- Both counters wrap at 2^32 (0xFFFFFFFF + 1 -> 0).
- iREN is never asserted in IDLE, and iaddr is stable for the whole FILL state.
- Conflict miss: two addresses with the same index but different tags evict each other. There is no replacement policy beyond overwrite.

Decomposition:
- cpu_types_pkg gains:
  - icachef_t, a packed address struct {tag, idx, bytoff}.
  - icache_frame_t, {valid, tag, data}.
  - icache_state_t, an enum {IDLE, FILL}.
  - The constant ICACHE_SETS = 16.
- The word_t type is reused from the same package.
- The block is a single module: the frame array, FSM and counters are small enough that a sub-module adds nothing.

Test Plan:
- Cold miss:
  - Stimulus: after reset, imemREN=1, imemaddr=0x00000000; memory returns iload=0x3C010001 with iwait held high 2 cycles.
  - Required: iREN=1 and iaddr=0x00000000 for 3 cycles; ihit=1 and imemload=0x3C010001 on the following cycle; miss_count=1.
- Sequential fetch:
  - Stimulus: addresses 0x0, 0x4, 0x8, 0xC, each filled once, then refetched.
  - Required: the second pass gives ihit=1 every cycle with no iREN; hit_count increments by 4.
- Conflict:
  - Stimulus: fill 0x00000004, then fetch 0x00000044 (same index 1, different tag).
  - Required: a miss and fill to 0x44; a refetch of 0x04 misses again; miss_count=3.
- Address change mid-fill:
  - Stimulus: miss on 0x10, then switch imemaddr to 0x20 while iwait=1.
  - Required: iaddr stays 0x10; frame 4 is installed; then 0x20 misses and fills.
- Flush:
  - Stimulus: icflush=1 while in FILL for 0x8.
  - Required: iREN=0 next cycle; no install; all previously hit addresses miss afterwards.
- Reset mid-fill and counter wrap:
  - Stimulus: nRST=0 during FILL.
  - Required: at the next edge, state is IDLE, iREN=0, counters are 0, and a prior hit address misses.
  - Stimulus: force hit_count to 0xFFFFFFFF, then one hit.
  - Required: hit_count reads 0.
